// File: rtl/nv_rampdp_pwr_gen2_if.sv
// Access and power-control bundle for the nv_rampdp_pwr_gen2 pseudo-dual-port RAM.
// The master drives write/read requests and power requests; the slave (the RAM)
// returns read data, status and the error pulse.
interface nv_rampdp_pwr_gen2_if #(
    parameter int AW    = 7,
    parameter int WIDTH = 16
);
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             re;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;
    logic             rd_vld;
    logic             sleep_req;
    logic             ret_req;
    logic             ready;
    logic [1:0]       pwr_state;
    logic             acc_err;

    modport master (
        output we, wa, wd, re, ra, sleep_req, ret_req,
        input  rd, rd_vld, ready, pwr_state, acc_err
    );

    modport slave (
        input  we, wa, wd, re, ra, sleep_req, ret_req,
        output rd, rd_vld, ready, pwr_state, acc_err
    );
endinterface

// File: rtl/nv_rampdp_pwr_gen2.sv
// Pseudo-dual-port RAM (one write, one read port) with per-entry valid bits,
// 1- or 2-cycle read latency, access-error reporting and a power-state FSM
// (ACTIVE / SLEEP / RETAIN / WAKE) that gates accesses and clamps read data.
//
// Power FSM states:
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ACTIVE    | normal operation, accesses accepted while no request pending
//   SLEEP     | array contents discarded (valid bitmap cleared on entry)
//   RETAIN    | array contents kept, no accesses
//   WAKE      | timed recovery, WAKE_CYC cycles before returning to ACTIVE
module nv_rampdp_pwr_gen2 #(
    parameter int DEPTH    = 80,
    parameter int AW       = 7,
    parameter int WIDTH    = 16,
    parameter int RD_LAT   = 1,
    parameter int BYPASS   = 0,
    parameter int WAKE_CYC = 4
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    nv_rampdp_pwr_gen2_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_RETAIN = 2'd2,
        ST_WAKE   = 2'd3
    } pwr_state_e;

    localparam int              CW        = $clog2(WAKE_CYC + 1);
    localparam logic [CW-1:0]   WAKE_LOAD = CW'(WAKE_CYC);
    localparam logic [AW:0]     DEPTH_L   = (AW + 1)'(DEPTH);

    pwr_state_e        state_q;
    pwr_state_e        state_nxt;
    logic [CW-1:0]     wcnt_q;
    logic [CW-1:0]     wcnt_nxt;
    logic              ready_q;
    logic              clr_vbits;

    logic [DEPTH-1:0]  vbits_q;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              req_any;
    logic              rdy;
    logic              wa_ok;
    logic              ra_ok;
    logic              wr_acc;
    logic              rd_acc;
    logic              wr_err;
    logic              rd_err;
    logic [WIDTH-1:0]  rdata;

    logic              fin_vld;
    logic [WIDTH-1:0]  fin_dat;
    logic              rd_busy;

    logic              rd_vld_q;
    logic [WIDTH-1:0]  rd_q;
    logic              acc_err_q;

    // ready_q is the registered "in ACTIVE" flag; a pending power request masks
    // it immediately so no access slips in while the FSM waits to leave ACTIVE.
    assign req_any = bus.sleep_req | bus.ret_req;
    assign rdy     = ready_q & ~req_any;

    assign wa_ok   = ({1'b0, bus.wa} < DEPTH_L);
    assign ra_ok   = ({1'b0, bus.ra} < DEPTH_L);

    assign wr_acc  = bus.we & rdy & wa_ok;
    assign rd_acc  = bus.re & rdy & ra_ok;
    assign wr_err  = bus.we & ~(rdy & wa_ok);
    assign rd_err  = bus.re & ~(rdy & ra_ok);

    // Read data at acceptance: invalid entries read as zero, optional write bypass.
    always_comb begin
        rdata = '0;
        if (ra_ok && vbits_q[bus.ra]) begin
            rdata = mem[bus.ra];
        end
        if ((BYPASS != 0) && wr_acc && (bus.wa == bus.ra)) begin
            rdata = bus.wd;
        end
    end

    // rd_busy flags a read that still has to reach the output register; the FSM
    // may not leave ACTIVE while it is set.
    if (RD_LAT == 2) begin : g_lat2
        logic             p_vld_q;
        logic [WIDTH-1:0] p_dat_q;

        // Extra pipeline stage for the two-cycle read latency.
        always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn) begin
                p_vld_q <= 1'b0;
                p_dat_q <= '0;
            end else begin
                p_vld_q <= rd_acc;
                if (rd_acc) begin
                    p_dat_q <= rdata;
                end
            end
        end

        assign fin_vld = p_vld_q;
        assign fin_dat = p_dat_q;
        assign rd_busy = p_vld_q;
    end else begin : g_lat1
        assign fin_vld = rd_acc;
        assign fin_dat = rdata;
        assign rd_busy = 1'b0;
    end

    // Output stage: rd holds between reads and is wiped outside ACTIVE so the
    // pre-sleep value never reappears after wake-up.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_vld_q <= 1'b0;
            rd_q     <= '0;
        end else begin
            rd_vld_q <= fin_vld;
            if (state_q != ST_ACTIVE) begin
                rd_q <= '0;
            end else if (fin_vld) begin
                rd_q <= fin_dat;
            end
        end
    end

    // Array write port; storage is intentionally not reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (wr_acc) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    // Per-entry valid bitmap, wiped whenever SLEEP is entered.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            vbits_q <= '0;
        end else if (clr_vbits) begin
            vbits_q <= '0;
        end else if (wr_acc) begin
            vbits_q[bus.wa] <= 1'b1;
        end
    end

    // Single error pulse per cycle, covering dropped reads and writes together.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            acc_err_q <= 1'b0;
        end else begin
            acc_err_q <= wr_err | rd_err;
        end
    end

    // Power FSM state, wake counter and registered ready.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= ST_WAKE;
            wcnt_q  <= WAKE_LOAD;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            wcnt_q  <= wcnt_nxt;
            ready_q <= (state_nxt == ST_ACTIVE);
        end
    end

    // Power FSM next state; ret_req wins over sleep_req everywhere.
    always_comb begin
        state_nxt = state_q;
        wcnt_nxt  = wcnt_q;
        unique case (state_q)
            ST_ACTIVE: begin
                if (!rd_busy) begin
                    if (bus.ret_req) begin
                        state_nxt = ST_RETAIN;
                    end else if (bus.sleep_req) begin
                        state_nxt = ST_SLEEP;
                    end
                end
            end
            ST_SLEEP: begin
                if (bus.ret_req) begin
                    state_nxt = ST_RETAIN;
                end else if (!bus.sleep_req) begin
                    state_nxt = ST_WAKE;
                    wcnt_nxt  = WAKE_LOAD;
                end
            end
            ST_RETAIN: begin
                if (!bus.ret_req) begin
                    if (bus.sleep_req) begin
                        state_nxt = ST_SLEEP;
                    end else begin
                        state_nxt = ST_WAKE;
                        wcnt_nxt  = WAKE_LOAD;
                    end
                end
            end
            ST_WAKE: begin
                if (bus.ret_req) begin
                    state_nxt = ST_RETAIN;
                end else if (bus.sleep_req) begin
                    state_nxt = ST_SLEEP;
                end else if (wcnt_q <= CW'(1)) begin
                    state_nxt = ST_ACTIVE;
                    wcnt_nxt  = '0;
                end else begin
                    wcnt_nxt  = wcnt_q - CW'(1);
                end
            end
            default: begin
                state_nxt = ST_WAKE;
                wcnt_nxt  = WAKE_LOAD;
            end
        endcase
        clr_vbits = (state_nxt == ST_SLEEP) && (state_q != ST_SLEEP);
    end

    assign bus.rd        = (state_q == ST_ACTIVE) ? rd_q : '0;
    assign bus.rd_vld    = rd_vld_q;
    assign bus.ready     = rdy;
    assign bus.pwr_state = state_q;
    assign bus.acc_err   = acc_err_q;

endmodule

// File: tb/tb_nv_rampdp_pwr_gen2.sv
// Bench for nv_rampdp_pwr_gen2: two instances (RD_LAT=2/BYPASS=0 and
// RD_LAT=1/BYPASS=1) share one stimulus stream and are compared every cycle
// against a transaction-level reference model (pending-read queue with due
// cycles, associative view of contents, deadline-based wake timing).
module tb_nv_rampdp_pwr_gen2;
    localparam int DEPTH    = 80;
    localparam int AW       = 7;
    localparam int WIDTH    = 16;
    localparam int WAKE_CYC = 4;

    logic             clk;
    logic             rstn;
    logic             we;
    logic             re;
    logic             sreq;
    logic             rreq;
    logic [AW-1:0]    wa;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] wd;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;
    int n     = 0;

    // reference model state, index 0 = RD_LAT 2 / no bypass, 1 = RD_LAT 1 / bypass
    int               st   [2];
    int               dl   [2];
    logic [WIDTH-1:0] mmem [2][DEPTH];
    logic             mval [2][DEPTH];
    int               qdue [2][$];
    logic [WIDTH-1:0] qdat [2][$];
    logic [WIDTH-1:0] last [2];
    logic             evld [2];
    logic             eerr [2];

    nv_rampdp_pwr_gen2_if #(.AW(AW), .WIDTH(WIDTH)) bus0 ();
    nv_rampdp_pwr_gen2_if #(.AW(AW), .WIDTH(WIDTH)) bus1 ();

    assign bus0.we = we;   assign bus0.wa = wa;   assign bus0.wd = wd;
    assign bus0.re = re;   assign bus0.ra = ra;
    assign bus0.sleep_req = sreq;  assign bus0.ret_req = rreq;
    assign bus1.we = we;   assign bus1.wa = wa;   assign bus1.wd = wd;
    assign bus1.re = re;   assign bus1.ra = ra;
    assign bus1.sleep_req = sreq;  assign bus1.ret_req = rreq;

    nv_rampdp_pwr_gen2 #(.DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH), .RD_LAT(2), .BYPASS(0),
                         .WAKE_CYC(WAKE_CYC)) u_dut0 (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (bus0)
    );

    nv_rampdp_pwr_gen2 #(.DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH), .RD_LAT(1), .BYPASS(1),
                         .WAKE_CYC(WAKE_CYC)) u_dut1 (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic byp(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_valid(input int i);
        for (int k = 0; k < DEPTH; k++) mval[i][k] = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            st[i]   = 3;
            dl[i]   = WAKE_CYC - 1;
            last[i] = '0;
            evld[i] = 1'b0;
            eerr[i] = 1'b0;
            qdue[i].delete();
            qdat[i].delete();
            clear_valid(i);
        end
    endtask

    // One clock edge of the reference model for instance i, using edge index n.
    task automatic model_step(input int i);
        logic             rdy;
        logic             wok;
        logic             rok;
        logic             pend;
        logic [WIDTH-1:0] d;
        rdy  = (st[i] == 0) && !sreq && !rreq;
        wok  = we && rdy && (int'(wa) < DEPTH);
        rok  = re && rdy && (int'(ra) < DEPTH);
        pend = 1'b0;
        d    = '0;
        for (int k = 0; k < qdue[i].size(); k++) if (qdue[i][k] >= n) pend = 1'b1;
        eerr[i] = (we && !wok) || (re && !rok);
        if (rok) begin
            if (byp(i) && wok && (wa == ra))  d = wd;
            else if (mval[i][ra])             d = mmem[i][ra];
            else                              d = '0;
            qdue[i].push_back(n + lat(i) - 1);
            qdat[i].push_back(d);
        end
        if (wok) begin
            mmem[i][wa] = wd;
            mval[i][wa] = 1'b1;
        end
        case (st[i])
            0: if (!pend && rreq) st[i] = 2;
               else if (!pend && sreq) begin st[i] = 1; clear_valid(i); end
            1: if (rreq) st[i] = 2;
               else if (!sreq) begin st[i] = 3; dl[i] = n + WAKE_CYC; end
            2: if (!rreq && sreq) begin st[i] = 1; clear_valid(i); end
               else if (!rreq) begin st[i] = 3; dl[i] = n + WAKE_CYC; end
            default: if (rreq) st[i] = 2;
               else if (sreq) begin st[i] = 1; clear_valid(i); end
               else if (n >= dl[i]) st[i] = 0;
        endcase
        evld[i] = 1'b0;
        if (qdue[i].size() > 0 && qdue[i][0] == n) begin
            evld[i] = 1'b1;
            d = qdat[i][0];
            void'(qdue[i].pop_front());
            void'(qdat[i].pop_front());
        end
        if (st[i] != 0)    last[i] = '0;
        else if (evld[i])  last[i] = d;
    endtask

    task automatic check_inst(input int i, input logic rdy, input logic [1:0] ps,
                              input logic [WIDTH-1:0] rdv, input logic rv, input logic ae);
        check($sformatf("i%0d_ready", i),   32'(rdy), 32'((st[i] == 0) && !sreq && !rreq));
        check($sformatf("i%0d_pwr", i),     32'(ps),  32'(st[i]));
        check($sformatf("i%0d_rd", i),      32'(rdv), 32'(last[i]));
        check($sformatf("i%0d_rd_vld", i),  32'(rv),  32'(evld[i]));
        check($sformatf("i%0d_acc_err", i), 32'(ae),  32'(eerr[i]));
    endtask

    task automatic check_both();
        check_inst(0, bus0.ready, bus0.pwr_state, bus0.rd, bus0.rd_vld, bus0.acc_err);
        check_inst(1, bus1.ready, bus1.pwr_state, bus1.rd, bus1.rd_vld, bus1.acc_err);
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        n++;
        #1;
        check_both();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle();
        sreq = 1'b0;
        rreq = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_both();
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0)      return AW'($urandom_range(DEPTH, 127));
        else if (r < 10) return AW'($urandom_range(0, 15));
        else             return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        rstn = 1'b0;
        idle();
        sreq = 1'b0;
        rreq = 1'b0;
        do_reset();

        // wake-up after reset: WAKE for four cycles, then ACTIVE
        repeat (3) cyc();
        check("wake_hold_pwr", 32'(bus0.pwr_state), 32'd3);
        cyc();
        check("wake_done_ready", 32'(bus0.ready), 32'd1);
        check("wake_done_pwr", 32'(bus1.pwr_state), 32'd0);

        // read of a never-written entry returns zero
        re = 1'b1; ra = 7'd5; cyc();
        re = 1'b0;
        check("inv_rd_l1", 32'(bus1.rd_vld), 32'd1);
        check("inv_rd_val", 32'(bus1.rd), 32'd0);
        cyc(); cyc();

        // write top entry, read it back next cycle
        we = 1'b1; wa = 7'd79; wd = 16'hBEEF; cyc();
        we = 1'b0; re = 1'b1; ra = 7'd79; cyc();
        re = 1'b0;
        check("beef_l1_vld", 32'(bus1.rd_vld), 32'd1);
        check("beef_l1_rd", 32'(bus1.rd), 32'hBEEF);
        check("beef_l2_early", 32'(bus0.rd_vld), 32'd0);
        cyc();
        check("beef_l2_vld", 32'(bus0.rd_vld), 32'd1);
        check("beef_l2_rd", 32'(bus0.rd), 32'hBEEF);
        cyc();

        // same-cycle write/read to one address
        we = 1'b1; wa = 7'd10; wd = 16'h1111; cyc();
        wd = 16'h2222; re = 1'b1; ra = 7'd10; cyc();
        idle();
        check("bypass_new", 32'(bus1.rd), 32'h2222);
        cyc();
        check("bypass_old", 32'(bus0.rd), 32'h1111);
        cyc();

        // error cases
        we = 1'b1; wa = 7'd80; wd = 16'hFFFF; cyc();
        idle();
        check("err_wr_oor", 32'(bus0.acc_err), 32'd1);
        cyc();
        check("err_pulse_end", 32'(bus0.acc_err), 32'd0);
        re = 1'b1; ra = 7'd127; cyc();
        idle();
        check("err_rd_oor", 32'(bus1.acc_err), 32'd1);
        check("err_rd_no_vld", 32'(bus1.rd_vld), 32'd0);
        cyc(); cyc();
        we = 1'b1; wa = 7'd100; re = 1'b1; ra = 7'd90; cyc();
        idle(); cyc();
        sreq = 1'b1; we = 1'b1; wa = 7'd20; wd = 16'h5555; cyc();
        idle();
        check("err_not_ready", 32'(bus0.acc_err), 32'd1);
        sreq = 1'b0;
        repeat (6) cyc();

        // retention keeps contents
        we = 1'b1; wa = 7'd3; wd = 16'hA5A5; cyc();
        idle(); rreq = 1'b1; repeat (3) cyc();
        check("ret_state", 32'(bus0.pwr_state), 32'd2);
        rreq = 1'b0; repeat (6) cyc();
        re = 1'b1; ra = 7'd3; cyc();
        re = 1'b0;
        check("ret_keep", 32'(bus1.rd), 32'hA5A5);
        cyc(); cyc();

        // sleep discards contents
        sreq = 1'b1; repeat (3) cyc();
        check("sleep_state", 32'(bus1.pwr_state), 32'd1);
        sreq = 1'b0; repeat (6) cyc();
        re = 1'b1; ra = 7'd3; cyc();
        re = 1'b0;
        check("sleep_lost", 32'(bus1.rd), 32'd0);
        cyc(); cyc();

        // sleep request while a two-cycle read is in flight
        we = 1'b1; wa = 7'd79; wd = 16'hBEEF; cyc();
        idle(); re = 1'b1; ra = 7'd79; cyc();
        re = 1'b0; sreq = 1'b1; cyc();
        check("inflight_vld", 32'(bus0.rd_vld), 32'd1);
        check("inflight_active", 32'(bus0.pwr_state), 32'd0);
        check("inflight_rd", 32'(bus0.rd), 32'hBEEF);
        cyc();
        check("inflight_slept", 32'(bus0.pwr_state), 32'd1);
        check("inflight_clamp", 32'(bus0.rd), 32'd0);
        sreq = 1'b0; repeat (6) cyc();

        // reset in the middle of a read
        we = 1'b1; wa = 7'd11; wd = 16'h7777; cyc();
        idle(); re = 1'b1; ra = 7'd11; cyc();
        do_reset();
        repeat (6) cyc();

        // randomized traffic with power requests
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) < 4) begin
                int r;
                r = int'($urandom_range(0, 9));
                sreq = (r == 7) || (r == 9);
                rreq = (r == 8) || (r == 9);
            end
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = rand_addr();
            ra = rand_addr();
            wd = WIDTH'($urandom);
            cyc();
        end
        idle(); sreq = 1'b0; rreq = 1'b0;
        repeat (10) cyc();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
